// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage core: stall/flush steering for load-use,
// taken branches, data-memory waits and multi-cycle mul/div, plus statistics.
module hazard_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFIDrs1,
  input  logic [4:0]       IFIDrs2,
  input  logic             IFIDuseRs1,
  input  logic             IFIDuseRs2,
  input  logic [4:0]       IDEXrd,
  input  logic             IDEXmemRead,
  input  logic             IDEXmulDiv,
  input  logic             EXbranchTaken,
  input  logic             EXMEMmemAccess,
  input  logic             DMEMready,
  input  logic             MDUdone,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             IDEXwrite,
  output logic             EXMEMwrite,
  output logic             IFIDflush,
  output logic             IDEXflush,
  output logic             EXMEMflush,
  output logic             MEMWBflush,
  output logic             MDUstart,
  output logic             MDUerror,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(MDU_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] tmo_cnt, tmo_nxt;
  logic       done_seen, done_nxt;
  logic       err_set;
  logic       mem_wait, load_use, mdu_fin;

  assign mem_wait = EXMEMmemAccess & ~DMEMready;
  assign load_use = IDEXmemRead & (IDEXrd != 5'd0) &
                    ((IFIDuseRs1 & (IFIDrs1 == IDEXrd)) |
                     (IFIDuseRs2 & (IFIDrs2 == IDEXrd)));
  // A done pulse that arrived under a memory wait is remembered in done_seen.
  assign mdu_fin  = MDUdone | done_seen;

  always_comb begin
    PCwrite    = 1'b1;
    IFIDwrite  = 1'b1;
    IDEXwrite  = 1'b1;
    EXMEMwrite = 1'b1;
    IFIDflush  = 1'b0;
    IDEXflush  = 1'b0;
    EXMEMflush = 1'b0;
    MEMWBflush = 1'b0;
    MDUstart   = 1'b0;
    state_nxt  = state;
    tmo_nxt    = tmo_cnt;
    done_nxt   = done_seen;
    err_set    = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            PCwrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXwrite  = 1'b0;
            EXMEMwrite = 1'b0;
            MEMWBflush = 1'b1;
          end else if (EXbranchTaken) begin
            IFIDflush = 1'b1;
            IDEXflush = 1'b1;
          end else if (IDEXmulDiv) begin
            MDUstart   = 1'b1;
            PCwrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXwrite  = 1'b0;
            EXMEMwrite = 1'b0;
            state_nxt  = MDU_BUSY;
            tmo_nxt    = 8'd0;
            done_nxt   = 1'b0;
          end else if (load_use) begin
            PCwrite   = 1'b0;
            IFIDwrite = 1'b0;
            IDEXflush = 1'b1;
          end
        end
        MDU_BUSY: begin
          PCwrite    = 1'b0;
          IFIDwrite  = 1'b0;
          IDEXwrite  = 1'b0;
          EXMEMflush = 1'b1;
          tmo_nxt    = tmo_cnt + 8'd1;
          if (mdu_fin && !mem_wait) begin
            PCwrite    = 1'b1;
            IFIDwrite  = 1'b1;
            IDEXwrite  = 1'b1;
            EXMEMflush = 1'b0;
            done_nxt   = 1'b0;
            state_nxt  = RUN;
          end else if (mdu_fin) begin
            EXMEMwrite = 1'b0;
            MEMWBflush = 1'b1;
            done_nxt   = 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort: release the pipe, the bubble in EX/MEM drops the op.
            PCwrite   = 1'b1;
            IFIDwrite = 1'b1;
            IDEXwrite = 1'b1;
            err_set   = 1'b1;
            state_nxt = RUN;
          end else if (mem_wait) begin
            EXMEMwrite = 1'b0;
            MEMWBflush = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      tmo_cnt    <= 8'd0;
      done_seen  <= 1'b0;
      MDUerror   <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_nxt;
      done_seen <= done_nxt;
      if (err_set) MDUerror <= 1'b1;
      if (!PCwrite && StallCount != '1) StallCount <= StallCount + 1'b1;
      if (IFIDflush && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench: the driver queues expected outputs per cycle, the
// monitor pops and compares them on the falling edge.
module tb_hazard_stall_controller;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  // {PCwrite,IFIDwrite,IDEXwrite,EXMEMwrite,IFIDflush,IDEXflush,EXMEMflush,MEMWBflush,MDUstart}
  localparam logic [8:0] NORM   = 9'b1111_0000_0;
  localparam logic [8:0] LU     = 9'b0011_0100_0;
  localparam logic [8:0] BR     = 9'b1111_1100_0;
  localparam logic [8:0] MW     = 9'b0000_0001_0;
  localparam logic [8:0] START  = 9'b0000_0000_1;
  localparam logic [8:0] BUSY   = 9'b0001_0010_0;
  localparam logic [8:0] BUSYMW = 9'b0000_0011_0;
  localparam logic [8:0] TMO    = 9'b1111_0010_0;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, md, br, ma, rdy, done;
  } in_t;

  typedef struct {
    logic [8:0] ctl;
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IFIDrs1, IFIDrs2, IDEXrd;
  logic IFIDuseRs1, IFIDuseRs2, IDEXmemRead, IDEXmulDiv, EXbranchTaken;
  logic EXMEMmemAccess, DMEMready, MDUdone;
  logic PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite;
  logic IFIDflush, IDEXflush, EXMEMflush, MEMWBflush, MDUstart, MDUerror;
  logic [CW-1:0] StallCount, FlushCount;

  exp_t q[$];
  int   n_pass = 0, n_total = 0;
  int   ms = 0, mf = 0;

  hazard_stall_controller #(.CNT_W(CW), .MDU_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2),
    .IFIDuseRs1(IFIDuseRs1), .IFIDuseRs2(IFIDuseRs2),
    .IDEXrd(IDEXrd), .IDEXmemRead(IDEXmemRead), .IDEXmulDiv(IDEXmulDiv),
    .EXbranchTaken(EXbranchTaken), .EXMEMmemAccess(EXMEMmemAccess),
    .DMEMready(DMEMready), .MDUdone(MDUdone),
    .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .IDEXwrite(IDEXwrite),
    .EXMEMwrite(EXMEMwrite), .IFIDflush(IFIDflush), .IDEXflush(IDEXflush),
    .EXMEMflush(EXMEMflush), .MEMWBflush(MEMWBflush), .MDUstart(MDUstart),
    .MDUerror(MDUerror), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctl", int'({PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite, IFIDflush,
                       IDEXflush, EXMEMflush, MEMWBflush, MDUstart}), int'(e.ctl));
      chk("MDUerror", int'(MDUerror), int'(e.err));
      chk("StallCount", int'(StallCount), e.stall);
      chk("FlushCount", int'(FlushCount), e.flush);
    end
  end

  task automatic step(input in_t v, input logic [8:0] ctl, input logic err);
    exp_t e;
    IFIDrs1 = v.rs1;  IFIDrs2 = v.rs2;
    IFIDuseRs1 = v.u1; IFIDuseRs2 = v.u2;
    IDEXrd = v.rd; IDEXmemRead = v.mr; IDEXmulDiv = v.md;
    EXbranchTaken = v.br; EXMEMmemAccess = v.ma; DMEMready = v.rdy; MDUdone = v.done;
    if (!rst_n) begin ms = 0; mf = 0; end
    e.ctl = ctl; e.err = err; e.stall = ms; e.flush = mf;
    q.push_back(e);
    if (rst_n) begin
      if (!ctl[8] && ms < MAX) ms++;
      if (ctl[4] && mf < MAX) mf++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    in_t idle, v;
    idle = '0; idle.rdy = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    step(idle, NORM, 1'b0);                      // reset state
    rst_n = 1'b1;
    step(idle, NORM, 1'b0);

    // load-use on rs2, then rd=0 must not stall
    v = idle; v.rd = 5'd5; v.mr = 1'b1; v.rs2 = 5'd5; v.u2 = 1'b1;
    step(v, LU, 1'b0);
    step(idle, NORM, 1'b0);
    v = idle; v.rd = 5'd0; v.mr = 1'b1; v.rs1 = 5'd0; v.u1 = 1'b1;
    step(v, NORM, 1'b0);

    // branch beats load-use
    v = idle; v.rd = 5'd7; v.mr = 1'b1; v.rs1 = 5'd7; v.u1 = 1'b1; v.br = 1'b1;
    step(v, BR, 1'b0);
    step(idle, NORM, 1'b0);

    // memWait defers a branch; branch beats mul/div
    v = idle; v.br = 1'b1; v.ma = 1'b1; v.rdy = 1'b0;
    step(v, MW, 1'b0);
    v.rdy = 1'b1;
    step(v, BR, 1'b0);
    v = idle; v.br = 1'b1; v.md = 1'b1;
    step(v, BR, 1'b0);

    // mul/div: start, 5 freeze cycles, done
    v = idle; v.md = 1'b1;
    step(v, START, 1'b0);
    for (int i = 0; i < 5; i++) step(v, BUSY, 1'b0);
    v.done = 1'b1;
    step(v, NORM, 1'b0);
    step(idle, NORM, 1'b0);

    // done arrives under a memory wait
    v = idle; v.md = 1'b1;
    step(v, START, 1'b0);
    step(v, BUSY, 1'b0);
    v.ma = 1'b1; v.rdy = 1'b0; v.done = 1'b1;
    step(v, BUSYMW, 1'b0);
    v.done = 1'b0;
    step(v, BUSYMW, 1'b0);
    step(v, BUSYMW, 1'b0);
    v.rdy = 1'b1;
    step(v, NORM, 1'b0);
    step(idle, NORM, 1'b0);

    // timeout after 8 busy cycles, error sticky
    rst_n = 1'b0;
    step(idle, NORM, 1'b0);
    rst_n = 1'b1;
    v = idle; v.md = 1'b1;
    step(v, START, 1'b0);
    for (int i = 0; i < 7; i++) step(v, BUSY, 1'b0);
    step(v, TMO, 1'b0);
    step(idle, NORM, 1'b1);
    step(idle, NORM, 1'b1);

    // 20-cycle stall saturates the 4-bit counter
    v = idle; v.rd = 5'd9; v.mr = 1'b1; v.rs1 = 5'd9; v.u1 = 1'b1;
    for (int i = 0; i < 20; i++) step(v, LU, 1'b1);
    step(idle, NORM, 1'b1);

    // asynchronous reset mid-busy, then a fresh start
    v = idle; v.md = 1'b1;
    step(v, START, 1'b1);
    step(v, BUSY, 1'b1);
    step(v, BUSY, 1'b1);
    rst_n = 1'b0;
    step(v, NORM, 1'b0);
    rst_n = 1'b1;
    step(idle, NORM, 1'b0);
    step(v, START, 1'b0);
    step(v, BUSY, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries never compared", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
